// File: rtl/rs_issue_scheduler.sv
// Age-ordered allocation and issue controller for a bank of reservation-station
// entries: lowest-free-index allocation on the decode side, oldest-ready grant
// on the issue side.
module rs_issue_scheduler #(
  parameter int unsigned NUM_RS     = 4,
  parameter int unsigned NUM_RS_LOG = $clog2(NUM_RS)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  decodeWriteEn_i,
  input  logic [NUM_RS-1:0]     rsReady_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [NUM_RS-1:0]     rsWriteEn_o,
  output logic [NUM_RS-1:0]     rsIssueStall_o,
  output logic [NUM_RS_LOG-1:0] grantIdx_o,
  output logic                  ready_o,
  output logic                  stall_o,
  output logic [NUM_RS_LOG:0]   occupancy_o
);

  localparam int unsigned CNT_W = NUM_RS_LOG + 1;

  logic [NUM_RS-1:0]     r_occ;
  logic [NUM_RS_LOG-1:0] r_queue [NUM_RS];
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_full;
  logic                  w_alloc;
  logic                  w_issue;
  logic [NUM_RS_LOG-1:0] w_target;
  logic                  w_grant_vld;
  logic [NUM_RS_LOG-1:0] w_grant_slot;
  logic [NUM_RS_LOG-1:0] w_grant_idx;
  logic [NUM_RS-1:0]     w_occ_nxt;
  logic [NUM_RS_LOG-1:0] w_queue_nxt [NUM_RS];
  logic [CNT_W-1:0]      w_cnt_after;
  logic [CNT_W-1:0]      w_cnt_nxt;

  // Fullness comes from registered count, so an issue cannot open a slot in the same cycle.
  assign w_full  = (r_cnt == CNT_W'(NUM_RS));
  assign w_alloc = decodeWriteEn_i & ~w_full & ~flush_i & ~reset_i;
  assign w_issue = w_grant_vld & ~stall_i & ~flush_i & ~reset_i;

  // Lowest-index free entry (descending scan so the lowest match wins).
  always_comb begin
    w_target = '0;
    for (int k = NUM_RS - 1; k >= 0; k--) begin
      if (!r_occ[k]) w_target = NUM_RS_LOG'(k);
    end
  end

  // Oldest valid queue slot whose entry has operands ready.
  always_comb begin
    w_grant_vld  = 1'b0;
    w_grant_slot = '0;
    w_grant_idx  = '0;
    for (int s = NUM_RS - 1; s >= 0; s--) begin
      if ((CNT_W'(s) < r_cnt) && rsReady_i[r_queue[s]]) begin
        w_grant_vld  = 1'b1;
        w_grant_slot = NUM_RS_LOG'(s);
        w_grant_idx  = r_queue[s];
      end
    end
  end

  // Next state: compact out the issued slot, then append the new entry at the tail.
  always_comb begin
    w_occ_nxt   = r_occ;
    w_queue_nxt = r_queue;
    w_cnt_after = r_cnt - CNT_W'(w_issue);
    if (w_issue) begin
      w_occ_nxt[w_grant_idx] = 1'b0;
      for (int s = 0; s < NUM_RS - 1; s++) begin
        if (NUM_RS_LOG'(s) >= w_grant_slot) w_queue_nxt[s] = r_queue[s+1];
      end
      w_queue_nxt[NUM_RS-1] = '0;
    end
    if (w_alloc) begin
      w_occ_nxt[w_target] = 1'b1;
      for (int s = 0; s < NUM_RS; s++) begin
        if (CNT_W'(s) == w_cnt_after) w_queue_nxt[s] = w_target;
      end
    end
    w_cnt_nxt = w_cnt_after + CNT_W'(w_alloc);
  end

  // State update: reset clears everything, flush drops all entries.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_occ <= '0;
      r_cnt <= '0;
      for (int s = 0; s < NUM_RS; s++) r_queue[s] <= '0;
    end else if (flush_i) begin
      r_occ <= '0;
      r_cnt <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_cnt   <= w_cnt_nxt;
      r_queue <= w_queue_nxt;
    end
  end

  // Output decode.
  always_comb begin
    rsWriteEn_o    = w_alloc ? (NUM_RS'(1) << w_target) : '0;
    rsIssueStall_o = w_issue ? ~(NUM_RS'(1) << w_grant_idx) : '1;
    grantIdx_o     = w_grant_idx;
    ready_o        = w_grant_vld;
    stall_o        = w_full;
    occupancy_o    = r_cnt;
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench for rs_issue_scheduler: an age-list reference model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_rs_issue_scheduler;

  localparam int N  = 4;
  localparam int LW = 2;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          decodeWriteEn_i;
  logic [N-1:0]  rsReady_i;
  logic          stall_i;
  logic          flush_i;
  logic [N-1:0]  rsWriteEn_o;
  logic [N-1:0]  rsIssueStall_o;
  logic [LW-1:0] grantIdx_o;
  logic          ready_o;
  logic          stall_o;
  logic [LW:0]   occupancy_o;

  always #5 clk_i = ~clk_i;

  rs_issue_scheduler #(.NUM_RS(N)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .decodeWriteEn_i(decodeWriteEn_i),
    .rsReady_i(rsReady_i), .stall_i(stall_i), .flush_i(flush_i),
    .rsWriteEn_o(rsWriteEn_o), .rsIssueStall_o(rsIssueStall_o),
    .grantIdx_o(grantIdx_o), .ready_o(ready_o), .stall_o(stall_o),
    .occupancy_o(occupancy_o)
  );

  typedef struct {
    logic [N-1:0]  we;
    logic [N-1:0]  ist;
    logic [LW-1:0] gidx;
    logic          rdy;
    logic          stl;
    logic [LW:0]   occ;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: entries listed oldest first, plus an occupied flag per entry.
  int order[$];
  bit occ_m[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_target();
    for (int k = 0; k < N; k++) if (!occ_m[k]) return k;
    return 0;
  endfunction

  function automatic int m_gpos();
    for (int p = 0; p < order.size(); p++) if (rsReady_i[order[p]]) return p;
    return -1;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int  gp    = m_gpos();
    bit  full  = (order.size() == N);
    bit  alloc = decodeWriteEn_i && !full && !flush_i && !reset_i;
    bit  iss   = (gp >= 0) && !stall_i && !flush_i && !reset_i;
    e.we   = alloc ? (N'(1) << m_target()) : '0;
    e.gidx = (gp >= 0) ? LW'(order[gp]) : '0;
    e.rdy  = (gp >= 0);
    e.ist  = iss ? ~(N'(1) << order[gp]) : '1;
    e.stl  = full;
    e.occ  = (LW+1)'(order.size());
    return e;
  endfunction

  task automatic model_update();
    int gp   = m_gpos();
    int t    = m_target();
    bit full = (order.size() == N);
    bit alloc = decodeWriteEn_i && !full && !flush_i && !reset_i;
    bit iss   = (gp >= 0) && !stall_i && !flush_i && !reset_i;
    if (reset_i || flush_i) begin
      order.delete();
      foreach (occ_m[k]) occ_m[k] = 1'b0;
    end else begin
      if (iss) begin
        occ_m[order[gp]] = 1'b0;
        order.delete(gp);
      end
      if (alloc) begin
        occ_m[t] = 1'b1;
        order.push_back(t);
      end
    end
  endtask

  task automatic drive(input logic rst, input logic dwe, input logic [N-1:0] rdy,
                       input logic stl, input logic fl);
    reset_i = rst; decodeWriteEn_i = dwe; rsReady_i = rdy; stall_i = stl; flush_i = fl;
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest prediction.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_wr_en",    32'(rsWriteEn_o),    32'(e.we));
      chk("sb_iss_stall", 32'(rsIssueStall_o), 32'(e.ist));
      chk("sb_grant",    32'(grantIdx_o),     32'(e.gidx));
      chk("sb_ready",    32'(ready_o),        32'(e.rdy));
      chk("sb_stall",    32'(stall_o),        32'(e.stl));
      chk("sb_occ",      32'(occupancy_o),    32'(e.occ));
      chk("we_onehot",   32'($countones(rsWriteEn_o) <= 1), 32'(1));
      chk("iss_onehot",  32'($countones(~rsIssueStall_o) <= 1), 32'(1));
    end
  end

  initial begin
    reset_i = 1'b1; decodeWriteEn_i = 1'b0; rsReady_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    foreach (occ_m[k]) occ_m[k] = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state with decode requesting
    drive(1, 1, 4'b1111, 0, 0);
    chk("rst_we", 32'(rsWriteEn_o), 32'h0);
    chk("rst_iss_stall", 32'(rsIssueStall_o), 32'hf);
    chk("rst_occ", 32'(occupancy_o), 32'h0);
    chk("rst_ready", 32'(ready_o), 32'h0);
    tick();

    // Fill from empty
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp_we;
      exp_we = (i < 4) ? (4'b0001 << i) : 4'b0000;
      drive(0, 1, 4'b0000, 0, 0);
      chk("fill_we", 32'(rsWriteEn_o), 32'(exp_we));
      chk("fill_stall", 32'(stall_o), 32'(i == 4));
      tick();
    end
    chk("fill_occ", 32'(occupancy_o), 32'd4);
    drive(0, 0, 4'b0000, 0, 1); tick();

    // Oldest-first: order becomes 1,2,3,0
    for (int i = 0; i < 3; i++) begin drive(0, 1, 4'b0000, 0, 0); tick(); end
    drive(0, 1, 4'b0001, 0, 0);
    chk("of_grant0", 32'(grantIdx_o), 32'd0);
    chk("of_we3", 32'(rsWriteEn_o), 32'b1000);
    tick();
    drive(0, 1, 4'b0000, 0, 0);
    chk("of_we0", 32'(rsWriteEn_o), 32'b0001);
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] g;
      logic [7:0] seq;
      seq = 8'b00_11_10_01;
      g = seq[2*i +: 2];
      drive(0, 0, 4'b1111, 0, 0);
      chk("of_grant", 32'(grantIdx_o), 32'(g));
      tick();
    end
    drive(0, 0, 4'b1111, 0, 0);
    chk("of_empty_ready", 32'(ready_o), 32'd0);
    tick();

    // Out-of-order ready
    for (int i = 0; i < 3; i++) begin drive(0, 1, 4'b0000, 0, 0); tick(); end
    drive(0, 0, 4'b0100, 0, 0);
    chk("ooo_grant", 32'(grantIdx_o), 32'd2);
    chk("ooo_iss_stall", 32'(rsIssueStall_o), 32'b1011);
    tick();
    drive(0, 0, 4'b0011, 0, 0);
    chk("ooo_grant_a", 32'(grantIdx_o), 32'd0);
    tick();
    drive(0, 0, 4'b0011, 0, 0);
    chk("ooo_grant_b", 32'(grantIdx_o), 32'd1);
    tick();

    // Stall hold
    drive(0, 1, 4'b0000, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'b0001, 1, 0);
      chk("hold_ready", 32'(ready_o), 32'd1);
      chk("hold_iss_stall", 32'(rsIssueStall_o), 32'hf);
      chk("hold_occ", 32'(occupancy_o), 32'd1);
      tick();
    end
    drive(0, 0, 4'b0001, 0, 0);
    chk("hold_release", 32'(rsIssueStall_o), 32'b1110);
    tick();
    chk("hold_occ_dec", 32'(occupancy_o), 32'd0);

    // Full with simultaneous issue
    for (int i = 0; i < 4; i++) begin drive(0, 1, 4'b0000, 0, 0); tick(); end
    drive(0, 1, 4'b0100, 0, 0);
    chk("full_we", 32'(rsWriteEn_o), 32'h0);
    chk("full_stall", 32'(stall_o), 32'd1);
    chk("full_iss", 32'(rsIssueStall_o), 32'b1011);
    tick();
    drive(0, 1, 4'b0000, 0, 0);
    chk("full_next_stall", 32'(stall_o), 32'd0);
    chk("full_next_we", 32'(rsWriteEn_o), 32'b0100);
    tick();

    // Flush, then reset, each with cnt=3 and activity requested
    for (int r = 0; r < 2; r++) begin
      drive(0, 0, 4'b0000, 0, 1); tick();
      for (int i = 0; i < 3; i++) begin drive(0, 1, 4'b0000, 0, 0); tick(); end
      drive(r == 1, 1, 4'b0001, 0, r == 0);
      chk("kill_we", 32'(rsWriteEn_o), 32'h0);
      chk("kill_iss", 32'(rsIssueStall_o), 32'hf);
      tick();
      drive(0, 0, 4'b1111, 0, 0);
      chk("kill_occ", 32'(occupancy_o), 32'd0);
      chk("kill_ready", 32'(ready_o), 32'd0);
      tick();
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60, N'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 3);
      tick();
    end

    reset_i = 1'b0; decodeWriteEn_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
